// File: rtl/pipelined_decoder.sv
// Three-stage decoder: accept/operand read, execute (drives the ALU), write-back/retire.
// One instruction per cycle with EX and WB forwarding; a HALT closes instr_ready for good.
module pipelined_decoder #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int OPCODE_W   = 8,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         instr_valid,
   output logic                         instr_ready,
   input  logic [OPCODE_W+2*DATA_W-1:0] instr_data,
   output logic [REG_ADDR_W-1:0]        gpr_r_addr_a,
   output logic [REG_ADDR_W-1:0]        gpr_r_addr_b,
   input  logic [DATA_W-1:0]            gpr_r_data_a,
   input  logic [DATA_W-1:0]            gpr_r_data_b,
   output logic                         gpr_w_enable,
   output logic [REG_ADDR_W-1:0]        gpr_w_addr,
   output logic [DATA_W-1:0]            gpr_w_data,
   output logic [2:0]                   alu_operation,
   output logic [DATA_W-1:0]            alu_A,
   output logic [DATA_W-1:0]            alu_B,
   input  logic [DATA_W-1:0]            alu_C,
   output logic                         halted,
   output logic                         illegal_op,
   output logic [CNT_W-1:0]             retire_count
);

   localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(8'h00);
   localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(8'h01);
   localparam logic [OPCODE_W-1:0] OP_LDR  = OPCODE_W'(8'h02);
   localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(8'h03);
   localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(8'h04);
   localparam logic [OPCODE_W-1:0] OP_INC  = OPCODE_W'(8'h05);
   localparam logic [OPCODE_W-1:0] OP_DEC  = OPCODE_W'(8'h06);
   localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(8'h0F);

   localparam logic [2:0] ALU_NONE = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_INC  = 3'd3;
   localparam logic [2:0] ALU_DEC  = 3'd4;

   function automatic logic op_writes(input logic [OPCODE_W-1:0] op);
      return (op == OP_LD)  || (op == OP_LDR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
   endfunction

   function automatic logic op_known(input logic [OPCODE_W-1:0] op);
      return op_writes(op) || (op == OP_NOP) || (op == OP_HALT);
   endfunction

   // ---------------- accept stage ----------------
   logic [OPCODE_W-1:0]   a_op;
   logic [DATA_W-1:0]     a_arg_a;
   logic [DATA_W-1:0]     a_arg_b;
   logic                  a_fire;
   logic [DATA_W-1:0]     fwd_a;
   logic [DATA_W-1:0]     fwd_b;
   logic [DATA_W-1:0]     opa_d;
   logic [DATA_W-1:0]     opb_d;
   logic                  unused_arg_a_hi;

   assign {a_op, a_arg_a, a_arg_b} = instr_data;
   assign unused_arg_a_hi = ^a_arg_a[DATA_W-1:REG_ADDR_W];

   // EX / WB state, declared here because the accept stage forwards from it
   logic                  ex_vld_q;
   logic [OPCODE_W-1:0]   ex_op_q;
   logic [REG_ADDR_W-1:0] ex_dst_q;
   logic [DATA_W-1:0]     ex_opa_q;
   logic [DATA_W-1:0]     ex_opb_q;
   logic                  ex_is_alu;
   logic                  ex_wr;
   logic [DATA_W-1:0]     ex_result;

   logic                  wb_vld_q;
   logic                  wb_halt_q;
   logic                  wb_ill_q;
   logic                  w_en_q;
   logic [REG_ADDR_W-1:0] w_addr_q;
   logic [DATA_W-1:0]     w_data_q;

   logic                  halt_seen_q;
   logic                  halted_q;
   logic                  illegal_q;
   logic [CNT_W-1:0]      retire_q;
   logic [CNT_W-1:0]      retire_d;

   assign instr_ready = !rst && !halt_seen_q;
   assign a_fire      = instr_valid && instr_ready;

   always_comb begin
      gpr_r_addr_a = '0;
      gpr_r_addr_b = '0;
      case (a_op)
         OP_LD:  gpr_r_addr_a = a_arg_b[REG_ADDR_W-1:0];
         OP_ADD,
         OP_SUB: begin
            gpr_r_addr_a = a_arg_a[REG_ADDR_W-1:0];
            gpr_r_addr_b = a_arg_b[REG_ADDR_W-1:0];
         end
         OP_INC,
         OP_DEC: gpr_r_addr_a = a_arg_a[REG_ADDR_W-1:0];
         default: ;
      endcase
   end

   // Youngest producer wins: the EX result is newer than what WB is writing.
   always_comb begin
      fwd_a = gpr_r_data_a;
      if (ex_wr && (ex_dst_q == gpr_r_addr_a))
         fwd_a = ex_result;
      else if (w_en_q && (w_addr_q == gpr_r_addr_a))
         fwd_a = w_data_q;

      fwd_b = gpr_r_data_b;
      if (ex_wr && (ex_dst_q == gpr_r_addr_b))
         fwd_b = ex_result;
      else if (w_en_q && (w_addr_q == gpr_r_addr_b))
         fwd_b = w_data_q;

      opa_d = '0;
      opb_d = '0;
      case (a_op)
         OP_LDR: opa_d = a_arg_b;
         OP_LD,
         OP_INC,
         OP_DEC: opa_d = fwd_a;
         OP_ADD,
         OP_SUB: begin
            opa_d = fwd_a;
            opb_d = fwd_b;
         end
         default: ;
      endcase
   end

   // ---------------- execute stage ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_vld_q <= 1'b0;
         ex_op_q  <= '0;
         ex_dst_q <= '0;
         ex_opa_q <= '0;
         ex_opb_q <= '0;
      end else begin
         ex_vld_q <= a_fire;
         if (a_fire) begin
            ex_op_q  <= a_op;
            ex_dst_q <= a_arg_a[REG_ADDR_W-1:0];
            ex_opa_q <= opa_d;
            ex_opb_q <= opb_d;
         end
      end
   end

   always_comb begin
      alu_operation = ALU_NONE;
      alu_A         = '0;
      alu_B         = '0;
      ex_is_alu     = 1'b0;
      if (ex_vld_q) begin
         case (ex_op_q)
            OP_ADD: begin
               alu_operation = ALU_ADD;
               alu_A         = ex_opa_q;
               alu_B         = ex_opb_q;
               ex_is_alu     = 1'b1;
            end
            OP_SUB: begin
               alu_operation = ALU_SUB;
               alu_A         = ex_opa_q;
               alu_B         = ex_opb_q;
               ex_is_alu     = 1'b1;
            end
            OP_INC: begin
               alu_operation = ALU_INC;
               alu_A         = ex_opa_q;
               ex_is_alu     = 1'b1;
            end
            OP_DEC: begin
               alu_operation = ALU_DEC;
               alu_A         = ex_opa_q;
               ex_is_alu     = 1'b1;
            end
            default: ;
         endcase
      end
      ex_result = ex_is_alu ? alu_C : ex_opa_q;
      ex_wr     = ex_vld_q && op_writes(ex_op_q);
   end

   // ---------------- write-back stage ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_vld_q  <= 1'b0;
         wb_halt_q <= 1'b0;
         wb_ill_q  <= 1'b0;
         w_en_q    <= 1'b0;
         w_addr_q  <= '0;
         w_data_q  <= '0;
      end else begin
         wb_vld_q  <= ex_vld_q;
         wb_halt_q <= ex_vld_q && (ex_op_q == OP_HALT);
         wb_ill_q  <= ex_vld_q && !op_known(ex_op_q);
         w_en_q    <= ex_wr;
         if (ex_wr) begin
            w_addr_q <= ex_dst_q;
            w_data_q <= ex_result;
         end
      end
   end

   assign gpr_w_enable = w_en_q;
   assign gpr_w_addr   = w_addr_q;
   assign gpr_w_data   = w_data_q;

   // ---------------- retirement / status ----------------
   assign retire_d = wb_vld_q ? retire_q + CNT_W'(1) : retire_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_seen_q <= 1'b0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
         retire_q    <= '0;
      end else begin
         if (a_fire && (a_op == OP_HALT))
            halt_seen_q <= 1'b1;
         if (wb_vld_q && wb_halt_q)
            halted_q <= 1'b1;
         illegal_q <= wb_vld_q && wb_ill_q;
         retire_q  <= retire_d;
      end
   end

   assign halted       = halted_q;
   assign illegal_op   = illegal_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Randomised and directed stimulus for pipelined_decoder against a program-order
// architectural model; a negedge monitor compares every WB slot with the scoreboard.
module tb_pipelined_decoder;
   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 3;
   localparam int OPCODE_W   = 8;
   localparam int CNT_W      = 4;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LD   = 8'h01;
   localparam logic [7:0] OP_LDR  = 8'h02;
   localparam logic [7:0] OP_ADD  = 8'h03;
   localparam logic [7:0] OP_SUB  = 8'h04;
   localparam logic [7:0] OP_INC  = 8'h05;
   localparam logic [7:0] OP_DEC  = 8'h06;
   localparam logic [7:0] OP_HALT = 8'h0F;
   localparam logic [7:0] OP_BAD  = 8'h5A;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [23:0] instr_data;
   logic [2:0]  gpr_r_addr_a;
   logic [2:0]  gpr_r_addr_b;
   logic [7:0]  gpr_r_data_a;
   logic [7:0]  gpr_r_data_b;
   logic        gpr_w_enable;
   logic [2:0]  gpr_w_addr;
   logic [7:0]  gpr_w_data;
   logic [2:0]  alu_operation;
   logic [7:0]  alu_A;
   logic [7:0]  alu_B;
   logic [7:0]  alu_C;
   logic        halted;
   logic        illegal_op;
   logic [3:0]  retire_count;

   pipelined_decoder #(
      .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .OPCODE_W(OPCODE_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .gpr_r_addr_a(gpr_r_addr_a), .gpr_r_addr_b(gpr_r_addr_b),
      .gpr_r_data_a(gpr_r_data_a), .gpr_r_data_b(gpr_r_data_b),
      .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data),
      .alu_operation(alu_operation), .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C),
      .halted(halted), .illegal_op(illegal_op), .retire_count(retire_count)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // GPR file and ALU environment
   logic [7:0] gpr [8];
   logic       gpr_clr;

   always @(posedge clk) begin
      if (gpr_clr) begin
         for (int i = 0; i < 8; i++) gpr[i] <= 8'h00;
      end else if (gpr_w_enable) begin
         gpr[gpr_w_addr] <= gpr_w_data;
      end
   end

   assign gpr_r_data_a = gpr[gpr_r_addr_a];
   assign gpr_r_data_b = gpr[gpr_r_addr_b];

   always_comb begin
      case (alu_operation)
         3'd1:    alu_C = alu_A + alu_B;
         3'd2:    alu_C = alu_A - alu_B;
         3'd3:    alu_C = alu_A + 8'd1;
         3'd4:    alu_C = alu_A - 8'd1;
         default: alu_C = 8'h00;
      endcase
   end

   // Scoreboard: one entry per accepted instruction, due in WB two cycles later
   typedef struct {
      int         cyc_wb;
      bit         wr;
      logic [2:0] addr;
      logic [7:0] dat;
      bit         ill;
      bit         halt;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ref_reg [8];
   int         exp_retire;
   bit         exp_halted;
   bit         exp_ill_next;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input int c);
      exp_t       e;
      logic [2:0] ra;
      logic [2:0] rb;
      ra       = a[2:0];
      rb       = b[2:0];
      e.cyc_wb = c + 2;
      e.wr     = 1'b0;
      e.addr   = ra;
      e.dat    = 8'h00;
      e.ill    = 1'b0;
      e.halt   = 1'b0;
      case (op)
         OP_NOP:  ;
         OP_LD:   begin e.wr = 1'b1; e.dat = ref_reg[rb]; end
         OP_LDR:  begin e.wr = 1'b1; e.dat = b; end
         OP_ADD:  begin e.wr = 1'b1; e.dat = ref_reg[ra] + ref_reg[rb]; end
         OP_SUB:  begin e.wr = 1'b1; e.dat = ref_reg[ra] - ref_reg[rb]; end
         OP_INC:  begin e.wr = 1'b1; e.dat = ref_reg[ra] + 8'd1; end
         OP_DEC:  begin e.wr = 1'b1; e.dat = ref_reg[ra] - 8'd1; end
         OP_HALT: e.halt = 1'b1;
         default: e.ill = 1'b1;
      endcase
      if (e.wr) ref_reg[ra] = e.dat;
      sb.push_back(e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("reset_outputs",
                  64'({instr_ready, gpr_w_enable, gpr_w_addr, gpr_w_data, alu_operation,
                       alu_A, alu_B, halted, illegal_op, retire_count}), 64'd0);
         end else begin
            check("illegal_op", 64'(illegal_op), 64'(exp_ill_next));
            check("halted", 64'(halted), 64'(exp_halted));
            check("retire_count", 64'(retire_count), 64'(exp_retire % 16));
            exp_ill_next = 1'b0;
            while (sb.size() > 0 && sb[0].cyc_wb < cyc) begin
               e = sb.pop_front();
               check("wb_missed", 64'(cyc), 64'(e.cyc_wb));
            end
            if (sb.size() > 0 && sb[0].cyc_wb == cyc) begin
               e = sb.pop_front();
               check("gpr_w_enable", 64'(gpr_w_enable), 64'(e.wr));
               if (e.wr) begin
                  check("gpr_w_addr", 64'(gpr_w_addr), 64'(e.addr));
                  check("gpr_w_data", 64'(gpr_w_data), 64'(e.dat));
               end
               exp_retire++;
               exp_ill_next = e.ill;
               if (e.halt) exp_halted = 1'b1;
            end else begin
               check("gpr_w_enable_idle", 64'(gpr_w_enable), 64'd0);
            end
            if (alu_operation == 3'd0)
               check("alu_idle_operands", 64'({alu_A, alu_B}), 64'd0);
            else if (alu_operation >= 3'd3)
               check("alu_B_unary", 64'(alu_B), 64'd0);
         end
      end
   end

   task automatic do_reset();
      rst          = 1'b1;
      gpr_clr      = 1'b1;
      instr_valid  = 1'b0;
      sb.delete();
      exp_retire   = 0;
      exp_halted   = 1'b0;
      exp_ill_next = 1'b0;
      for (int i = 0; i < 8; i++) ref_reg[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      gpr_clr = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 after acceptance or a bounded wait
   task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, output bit acc);
      int waited;
      waited      = 0;
      acc         = 1'b0;
      instr_valid = 1'b1;
      instr_data  = {op, a, b};
      while (!acc && waited < 8) begin
         @(negedge clk);
         if (instr_ready) begin
            acc = 1'b1;
            model(op, a, b, cyc);
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue_ok(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      bit acc;
      issue(op, a, b, acc);
      check("accepted", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      instr_valid = 1'b0;
      instr_data  = 24'($urandom);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      bit         acc;
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      rst         = 1'b0;
      gpr_clr     = 1'b1;
      instr_valid = 1'b0;
      instr_data  = '0;
      #1;
      do_reset();

      // basic EX forward, forward priority, wrap-around
      issue_ok(OP_LDR, 8'h01, 8'h05);
      issue_ok(OP_ADD, 8'h01, 8'h01);
      issue_ok(OP_LDR, 8'h02, 8'h10);
      issue_ok(OP_LDR, 8'h02, 8'h20);
      issue_ok(OP_INC, 8'h02, 8'h00);
      issue_ok(OP_LDR, 8'h00, 8'hFF);
      issue_ok(OP_INC, 8'h00, 8'h00);
      issue_ok(OP_LDR, 8'h04, 8'h00);
      issue_ok(OP_LDR, 8'h05, 8'h01);
      issue_ok(OP_SUB, 8'h04, 8'h05);
      idle(1);
      issue_ok(OP_LD,  8'h06, 8'h04);
      issue_ok(OP_DEC, 8'h06, 8'h00);
      idle(4);
      check("sb_drained_basic", 64'(sb.size()), 64'd0);

      // illegal opcode then NOP
      do_reset();
      issue_ok(OP_BAD, 8'h03, 8'h03);
      issue_ok(OP_NOP, 8'h00, 8'h00);
      idle(4);
      check("illegal_retire_count", 64'(retire_count), 64'd2);

      // HALT drain
      do_reset();
      issue_ok(OP_LDR, 8'h03, 8'h07);
      issue_ok(OP_HALT, 8'h00, 8'h00);
      issue(OP_ADD, 8'h03, 8'h03, acc);
      check("halt_blocks_younger", 64'(acc), 64'd0);
      idle(2);
      check("halt_retire_count", 64'(retire_count), 64'd2);
      check("halt_sticky", 64'(halted), 64'd1);
      check("halt_ready_low", 64'(instr_ready), 64'd0);

      // counter wrap with a 4-bit counter
      do_reset();
      for (int i = 0; i < 17; i++) issue_ok(OP_NOP, 8'(i), 8'h00);
      idle(4);
      check("retire_wrap", 64'(retire_count), 64'd1);

      // asynchronous reset with ADD in EX and LDR in WB
      do_reset();
      issue_ok(OP_LDR, 8'h01, 8'h05);
      issue_ok(OP_ADD, 8'h01, 8'h01);
      instr_valid = 1'b0;
      check("pre_rst_wb_en", 64'(gpr_w_enable), 64'd1);
      check("pre_rst_ex_op", 64'(alu_operation), 64'd1);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("async_rst_outputs",
            64'({instr_ready, gpr_w_enable, gpr_w_addr, gpr_w_data, alu_operation,
                 alu_A, alu_B, halted, illegal_op, retire_count}), 64'd0);
      do_reset();
      idle(5);
      check("post_rst_retire", 64'(retire_count), 64'd0);

      // randomised mix with bubbles
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            case ($urandom_range(0, 9))
               0:       op = OP_NOP;
               1:       op = OP_LD;
               2, 9:    op = OP_LDR;
               3, 7:    op = OP_ADD;
               4:       op = OP_SUB;
               5:       op = OP_INC;
               6:       op = OP_DEC;
               default: op = 8'($urandom_range(16, 255));
            endcase
            a = 8'($urandom) & 8'hFB;
            b = 8'($urandom);
            issue_ok(op, a, b);
         end
      end
      idle(5);
      check("sb_drained_random", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_decoder.md
# pipelined_decoder

Parametrised, pipelined successor to the combinational instruction decoder. It accepts instruction words from the fetch/ROM side over a valid/ready handshake and reads GPR operands. It drives the ALU from a registered execute stage and writes results back to the GPR file from a registered write-back stage. Operand forwarding removes read-after-write stalls, so throughput is one instruction per cycle. New over the previous decoder: widths are parametrised, and the block adds a HALT opcode, an illegal-opcode flag and a retired-instruction counter.

## Interface
- DATA_W, 8, GPR/ALU data width; also width of arg_a and arg_b fields
- REG_ADDR_W, 3, GPR address width; taken from the low bits of arg_a/arg_b
- OPCODE_W, 8, opcode field width
- CNT_W, 16, retired-instruction counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instr_data holds a valid instruction
- instr_ready  out  1  block can accept an instruction this cycle
- instr_data  in  OPCODE_W+2*DATA_W  {opcode, arg_a, arg_b}, opcode in MSBs
- gpr_r_addr_a  out  REG_ADDR_W  combinational GPR read address A
- gpr_r_addr_b  out  REG_ADDR_W  combinational GPR read address B
- gpr_r_data_a  in  DATA_W  combinational GPR read data A
- gpr_r_data_b  in  DATA_W  combinational GPR read data B
- gpr_w_enable  out  1  registered GPR write strobe
- gpr_w_addr  out  REG_ADDR_W  registered GPR write address
- gpr_w_data  out  DATA_W  registered GPR write data
- alu_operation  out  3  ALU op; encodings from global_params.vh
- alu_A, alu_B  out  DATA_W  ALU operands
- alu_C  in  DATA_W  combinational ALU result
- halted  out  1  HALT has retired; sticky until rst
- illegal_op  out  1  one-cycle pulse when an unknown opcode retires
- retire_count  out  CNT_W  count of retired instructions

## Operation
- Opcode values: NOP, LD, LDR, ADD, SUB, INC and DEC use their existing values from global_params.vh. HALT is added to the same header.
- Accept (A) stage:
  - A handshake occurs when instr_valid && instr_ready.
  - gpr_r_addr_a = arg_b[REG_ADDR_W-1:0] for LD. For ADD, SUB, INC and DEC it is arg_a[REG_ADDR_W-1:0]. Otherwise it is 0.
  - gpr_r_addr_b = arg_b[REG_ADDR_W-1:0] for ADD and SUB; otherwise 0.
  - On a handshake, the EX register captures: valid, opcode, destination = arg_a[REG_ADDR_W-1:0], and operand values.
  - For LDR, operand A is the immediate arg_b.
- Forwarding, applied per operand at A-stage capture, in priority order:
  1. If EX is valid, writes, and its destination equals the read address, use the EX result (alu_C, or the EX operand A for LD/LDR).
  2. Else, if WB has gpr_w_enable set and gpr_w_addr equals the read address, use gpr_w_data.
  3. Else use the GPR read data.
- EX stage:
  - For ADD, SUB, INC and DEC, drives alu_A, alu_B and alu_operation (addition, substraction, increment, decrement) from EX registers.
  - For all other opcodes, including an empty stage, the three ALU outputs are 0.
  - INC/DEC drive alu_B = 0.
  - Results: ADD/SUB/INC/DEC produce alu_C. LD produces operand A (GPR copy). LDR produces operand A (immediate).
  - Arithmetic wraps modulo 2^DATA_W; carry is discarded.
- WB stage:
  - Registers the EX result.
  - gpr_w_enable = 1 only for LD, LDR, ADD, SUB, INC and DEC. NOP, HALT and unknown opcodes do not write.
- Retirement:
  - Every valid instruction leaving WB increments retire_count by 1, including NOP, HALT and illegal opcodes.
  - retire_count wraps from 2^CNT_W-1 to 0.
  - An unknown opcode behaves as NOP and pulses illegal_op when it retires.
- HALT:
  - Once HALT is accepted, instr_ready = 0 from the next cycle until rst. Younger instructions are never accepted.
  - Older instructions in EX and WB drain normally.
  - halted rises in the cycle after HALT leaves WB.
- instr_ready = !rst && !halt_seen. There is no backpressure from downstream.

## Timing
- Reset values:
  - instr_ready 0 while rst is high, 1 after release.
  - All pipeline valids 0; gpr_w_enable 0; gpr_w_addr 0; gpr_w_data 0.
  - alu_operation 0; alu_A 0; alu_B 0.
  - halted 0; illegal_op 0; retire_count 0.
- Latency:
  - Instruction accepted at cycle N is in EX during N+1.
  - gpr_w_* are asserted during N+2; the GPR commits at the edge ending N+2.
  - retire_count increments at that same edge.
  - An instruction accepted at N+3 reads the committed value directly from the GPR.
- Back-to-back dependent instructions need no bubble:
  - gap 1 uses the EX forward;
  - gap 2 uses the WB forward;
  - gap 3 or more uses the GPR file.
- A bubble (no handshake) inserts an invalid EX entry. Invalid entries do not forward, write or count.
- If rst is asserted mid-operation, all in-flight instructions are discarded immediately, without waiting for a clock edge. Nothing in flight is written after release.

## Test plan
- Basic pipeline:
  - Stimulus: LDR r1,0x05, then ADD r1,r1 issued back-to-back.
  - Required: gpr_w writes r1=0x05 at N+2 and r1=0x0A at N+3, with no stall (EX forward).
- Forward priority:
  - Stimulus: LDR r2,0x10; LDR r2,0x20; INC r2, issued consecutively.
  - Required: INC writes r2=0x21 (EX result wins over WB).
- Wrap:
  - Stimulus: LDR r0,0xFF, then INC r0.
  - Required: INC writes r0=0x00.
  - Stimulus: with DATA_W=8, SUB of 0x00-0x01.
  - Required: result 0xFF.
- HALT drain:
  - Stimulus: LDR r3,0x07; HALT; ADD r3,r3, all held valid.
  - Required: the ADD is never accepted; instr_ready falls the cycle after HALT is accepted; r3=0x07 written; halted rises two cycles after r3 is written; retire_count=2.
- Illegal opcode and counter:
  - Stimulus: unknown opcode, then NOP.
  - Required: no GPR writes, illegal_op pulses once, retire_count=2.
  - Stimulus: with CNT_W=4, 17 instructions.
  - Required: retire_count reads 1 after the last retires.
- Async reset:
  - Stimulus: assert rst mid-cycle while ADD is in EX.
  - Required: gpr_w_enable and all other outputs reach reset values before the next edge; no write follows release.
